// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control sequencer: FETCH/DECODE/EXEC/MEM/WB stepping with
// a memory-ready handshake, per-state datapath strobes and a retire counter.
module mips_multicycle_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode_i,
  input  logic [5:0]  funct_i,
  input  logic        mem_ready_i,
  input  logic        cmp_eq_i,
  output logic [4:0]  alu_operation_o,
  output logic        alu_src_b_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        iord_o,
  output logic        ir_write_o,
  output logic        pc_write_o,
  output logic        pc_src_o,
  output logic        reg_write_o,
  output logic        reg_dst_o,
  output logic        mem_to_reg_o,
  output logic        link_o,
  output logic        illegal_o,
  output logic [31:0] instr_count_o,
  output logic [2:0]  state_dbg_o
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_TRAP   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CL_ALU_R = 3'd0,
    CL_ALU_I = 3'd1,
    CL_LW    = 3'd2,
    CL_SW    = 3'd3,
    CL_BEQ   = 3'd4,
    CL_BNE   = 3'd5,
    CL_JMP   = 3'd6,
    CL_JAL   = 3'd7
  } class_e;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_OR   = 5'd2;
  localparam logic [4:0] ALU_ORI  = 5'd3;
  localparam logic [4:0] ALU_SRL  = 5'd4;
  localparam logic [4:0] ALU_SLL  = 5'd5;
  localparam logic [4:0] ALU_LUI  = 5'd6;
  localparam logic [4:0] ALU_ANDI = 5'd7;
  localparam logic [4:0] ALU_BEQ  = 5'd10;
  localparam logic [4:0] ALU_BNE  = 5'd11;
  localparam logic [4:0] ALU_NOR  = 5'd12;
  localparam logic [4:0] ALU_AND  = 5'd13;
  localparam logic [4:0] ALU_JMP  = 5'd14;
  localparam logic [4:0] ALU_JAL  = 5'd15;

  state_e      state_q, state_d;
  class_e      class_q, class_d;
  logic [4:0]  alu_q, alu_d;
  logic [31:0] cnt_q, cnt_d;

  class_e      dec_class;
  logic [4:0]  dec_alu;
  logic        dec_legal;
  logic        retire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      class_q <= CL_ALU_R;
      alu_q   <= ALU_ADD;
      cnt_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      class_q <= class_d;
      alu_q   <= alu_d;
      cnt_q   <= cnt_d;
    end
  end

  // Instruction decode; only consumed while in DECODE.
  always_comb begin
    dec_class = CL_ALU_R;
    dec_alu   = ALU_ADD;
    dec_legal = 1'b1;
    case (opcode_i)
      6'h00: begin
        case (funct_i)
          6'h20:   dec_alu = ALU_ADD;
          6'h22:   dec_alu = ALU_SUB;
          6'h24:   dec_alu = ALU_AND;
          6'h25:   dec_alu = ALU_OR;
          6'h27:   dec_alu = ALU_NOR;
          6'h00:   dec_alu = ALU_SLL;
          6'h02:   dec_alu = ALU_SRL;
          default: dec_legal = 1'b0;
        endcase
      end
      6'h08: begin dec_class = CL_ALU_I; dec_alu = ALU_ADD;  end
      6'h0C: begin dec_class = CL_ALU_I; dec_alu = ALU_ANDI; end
      6'h0D: begin dec_class = CL_ALU_I; dec_alu = ALU_ORI;  end
      6'h0F: begin dec_class = CL_ALU_I; dec_alu = ALU_LUI;  end
      6'h23: begin dec_class = CL_LW;    dec_alu = ALU_ADD;  end
      6'h2B: begin dec_class = CL_SW;    dec_alu = ALU_ADD;  end
      6'h04: begin dec_class = CL_BEQ;   dec_alu = ALU_BEQ;  end
      6'h05: begin dec_class = CL_BNE;   dec_alu = ALU_BNE;  end
      6'h02: begin dec_class = CL_JMP;   dec_alu = ALU_JMP;  end
      6'h03: begin dec_class = CL_JAL;   dec_alu = ALU_JAL;  end
      default: dec_legal = 1'b0;
    endcase
  end

  // Handshake: mem_read_o/mem_write_o and iord_o stay asserted each cycle of
  // FETCH/MEM until mem_ready_i is seen high; the transfer completes in that cycle.
  always_comb begin
    state_d         = state_q;
    class_d         = class_q;
    alu_d           = alu_q;
    retire          = 1'b0;
    alu_operation_o = ALU_ADD;
    alu_src_b_o     = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    iord_o          = 1'b0;
    ir_write_o      = 1'b0;
    pc_write_o      = 1'b0;
    pc_src_o        = 1'b0;
    reg_write_o     = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    link_o          = 1'b0;
    illegal_o       = 1'b0;
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        mem_read_o = 1'b1;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          pc_write_o = 1'b1;
          state_d    = ST_DECODE;
        end
      end
      ST_DECODE: begin
        class_d = dec_class;
        alu_d   = dec_alu;
        state_d = dec_legal ? ST_EXEC : ST_TRAP;
      end
      ST_EXEC: begin
        alu_operation_o = alu_q;
        case (class_q)
          CL_ALU_R: state_d = ST_WB;
          CL_ALU_I: begin alu_src_b_o = 1'b1; state_d = ST_WB;  end
          CL_LW,
          CL_SW:    begin alu_src_b_o = 1'b1; state_d = ST_MEM; end
          CL_BEQ: begin
            pc_write_o = cmp_eq_i;
            pc_src_o   = 1'b1;
            state_d    = ST_FETCH;
            retire     = 1'b1;
          end
          CL_BNE: begin
            pc_write_o = !cmp_eq_i;
            pc_src_o   = 1'b1;
            state_d    = ST_FETCH;
            retire     = 1'b1;
          end
          CL_JMP: begin
            pc_write_o = 1'b1;
            pc_src_o   = 1'b1;
            state_d    = ST_FETCH;
            retire     = 1'b1;
          end
          CL_JAL: begin
            pc_write_o  = 1'b1;
            pc_src_o    = 1'b1;
            reg_write_o = 1'b1;
            link_o      = 1'b1;
            state_d     = ST_FETCH;
            retire      = 1'b1;
          end
          default: state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        alu_operation_o = ALU_ADD;
        alu_src_b_o     = 1'b1;
        iord_o          = 1'b1;
        mem_read_o      = (class_q == CL_LW);
        mem_write_o     = (class_q == CL_SW);
        if (mem_ready_i) begin
          state_d = (class_q == CL_LW) ? ST_WB : ST_FETCH;
          retire  = (class_q != CL_LW);
        end
      end
      ST_WB: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = (class_q == CL_ALU_R);
        mem_to_reg_o = (class_q == CL_LW);
        state_d      = ST_FETCH;
        retire       = 1'b1;
      end
      ST_TRAP: begin
        illegal_o = 1'b1;
        state_d   = ST_FETCH;
      end
      default: state_d = ST_IDLE;
    endcase
    cnt_d = retire ? cnt_q + 32'd1 : cnt_q;
  end

  assign instr_count_o = cnt_q;
  assign state_dbg_o   = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: instruction table replayed through a
// per-cycle expected-output queue, plus hand sequences for waits and reset.
module tb_mips_multicycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode, funct;
  logic        mem_ready, cmp_eq;
  logic [4:0]  alu_op;
  logic        src_b, mem_read, mem_write, iord, ir_write, pc_write, pc_src;
  logic        reg_write, reg_dst, mem_to_reg, link, illegal;
  logic [31:0] count;
  logic [2:0]  state_dbg;

  mips_multicycle_control dut (
    .clk(clk), .reset(rst), .opcode_i(opcode), .funct_i(funct),
    .mem_ready_i(mem_ready), .cmp_eq_i(cmp_eq),
    .alu_operation_o(alu_op), .alu_src_b_o(src_b),
    .mem_read_o(mem_read), .mem_write_o(mem_write), .iord_o(iord),
    .ir_write_o(ir_write), .pc_write_o(pc_write), .pc_src_o(pc_src),
    .reg_write_o(reg_write), .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg),
    .link_o(link), .illegal_o(illegal), .instr_count_o(count),
    .state_dbg_o(state_dbg)
  );

  always #5 clk = ~clk;

  localparam int W = 17;
  localparam logic [W-1:0] SRCB = 17'h00800, MRD = 17'h00400, MWR = 17'h00200;
  localparam logic [W-1:0] IORD = 17'h00100, IRW = 17'h00080, PCW = 17'h00040;
  localparam logic [W-1:0] PCS  = 17'h00020, RW  = 17'h00010, RDST = 17'h00008;
  localparam logic [W-1:0] M2R  = 17'h00004, LNK = 17'h00002, ILL  = 17'h00001;
  localparam logic [W-1:0] F_RDY = MRD | IRW | PCW;
  localparam logic [2:0] ST_IDLE = 3'd0;

  typedef struct {
    logic [5:0]            op;
    logic [5:0]            fn;
    logic                  cmp;
    int                    ncyc;
    logic [2:0][W-1:0]     v;
    int                    inc;
  } vec_t;

  vec_t            tbl[$];
  logic [W-1:0]    exp_q[$];
  int              errors = 0;
  int              checks = 0;
  logic [31:0]     exp_count = 32'd0;

  function automatic logic [W-1:0] alu(input int c);
    return W'(c) << 12;
  endfunction

  function automatic logic [W-1:0] pack_out();
    return {alu_op, src_b, mem_read, mem_write, iord, ir_write, pc_write,
            pc_src, reg_write, reg_dst, mem_to_reg, link, illegal};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic add_vec(input logic [5:0] op, input logic [5:0] fn, input logic cmp,
                         input int ncyc, input logic [W-1:0] v0, input logic [W-1:0] v1,
                         input logic [W-1:0] v2, input int inc);
    vec_t t;
    t.op = op; t.fn = fn; t.cmp = cmp; t.ncyc = ncyc;
    t.v[0] = v0; t.v[1] = v1; t.v[2] = v2; t.inc = inc;
    tbl.push_back(t);
  endtask

  // Called at posedge+1 of the cycle under test; returns at posedge+1 of the next.
  task automatic step(input logic rdy, input logic cmp, input logic [W-1:0] exp,
                      input string name);
    logic [W-1:0] e;
    mem_ready = rdy;
    cmp_eq    = cmp;
    exp_q.push_back(exp);
    @(negedge clk);
    e = exp_q.pop_front();
    chk(name, 32'(pack_out()), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input int idx);
    vec_t  t;
    string nm;
    t = tbl[idx];
    opcode = t.op;
    funct  = t.fn;
    nm = $sformatf("op%02h_fn%02h_c%0d", t.op, t.fn, t.cmp);
    step(1'b1, t.cmp, F_RDY, {nm, "_fetch"});
    step(1'b1, t.cmp, '0, {nm, "_decode"});
    for (int k = 0; k < t.ncyc - 2; k++)
      step(1'b1, t.cmp, t.v[k], $sformatf("%s_c%0d", nm, k + 2));
    exp_count = exp_count + 32'(t.inc);
    chk({nm, "_count"}, count, exp_count);
  endtask

  initial begin
    // R-type
    add_vec(6'h00, 6'h20, 1'b0, 4, alu(0),  RW | RDST, '0, 1);
    add_vec(6'h00, 6'h22, 1'b1, 4, alu(1),  RW | RDST, '0, 1);
    add_vec(6'h00, 6'h24, 1'b0, 4, alu(13), RW | RDST, '0, 1);
    add_vec(6'h00, 6'h25, 1'b0, 4, alu(2),  RW | RDST, '0, 1);
    add_vec(6'h00, 6'h27, 1'b1, 4, alu(12), RW | RDST, '0, 1);
    add_vec(6'h00, 6'h00, 1'b0, 4, alu(5),  RW | RDST, '0, 1);
    add_vec(6'h00, 6'h02, 1'b0, 4, alu(4),  RW | RDST, '0, 1);
    // ALU immediate (funct is a don't-care)
    add_vec(6'h08, 6'($urandom_range(0, 63)), 1'b0, 4, alu(0) | SRCB, RW, '0, 1);
    add_vec(6'h0C, 6'($urandom_range(0, 63)), 1'b1, 4, alu(7) | SRCB, RW, '0, 1);
    add_vec(6'h0D, 6'($urandom_range(0, 63)), 1'b0, 4, alu(3) | SRCB, RW, '0, 1);
    add_vec(6'h0F, 6'($urandom_range(0, 63)), 1'b0, 4, alu(6) | SRCB, RW, '0, 1);
    // Memory
    add_vec(6'h23, 6'($urandom_range(0, 63)), 1'b0, 5, SRCB, SRCB | IORD | MRD, RW | M2R, 1);
    add_vec(6'h2B, 6'($urandom_range(0, 63)), 1'b1, 4, SRCB, SRCB | IORD | MWR, '0, 1);
    // Branches and jumps
    add_vec(6'h04, 6'h00, 1'b1, 3, alu(10) | PCW | PCS, '0, '0, 1);
    add_vec(6'h04, 6'h00, 1'b0, 3, alu(10) | PCS, '0, '0, 1);
    add_vec(6'h05, 6'h00, 1'b0, 3, alu(11) | PCW | PCS, '0, '0, 1);
    add_vec(6'h05, 6'h00, 1'b1, 3, alu(11) | PCS, '0, '0, 1);
    add_vec(6'h02, 6'h11, 1'b0, 3, alu(14) | PCW | PCS, '0, '0, 1);
    add_vec(6'h03, 6'h11, 1'b0, 3, alu(15) | PCW | PCS | RW | LNK, '0, '0, 1);
    // Illegal
    add_vec(6'h3F, 6'h20, 1'b0, 3, ILL, '0, '0, 0);
    add_vec(6'h00, 6'h3F, 1'b0, 3, ILL, '0, '0, 0);
    add_vec(6'h01, 6'h00, 1'b1, 3, ILL, '0, '0, 0);

    rst = 1'b1; opcode = '0; funct = '0; mem_ready = 1'b0; cmp_eq = 1'b0;
    #1;
    chk("reset_outputs", 32'(pack_out()), 32'd0);
    chk("reset_count", count, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 32'(state_dbg), 32'(ST_IDLE));
    rst = 1'b0;
    step(1'b1, 1'b0, '0, "idle_after_reset");

    for (int i = 0; i < tbl.size(); i++) run_instr(i);
    for (int i = 0; i < 20; i++) run_instr($urandom_range(0, tbl.size() - 1));

    // lw with two not-ready cycles in both FETCH and MEM: 9 cycles
    opcode = 6'h23; funct = 6'h00;
    step(1'b0, 1'b0, MRD, "lw_fetch_wait0");
    step(1'b0, 1'b0, MRD, "lw_fetch_wait1");
    step(1'b1, 1'b0, F_RDY, "lw_fetch_ready");
    step(1'b1, 1'b0, '0, "lw_decode");
    step(1'b1, 1'b0, SRCB, "lw_exec");
    step(1'b0, 1'b0, SRCB | IORD | MRD, "lw_mem_wait0");
    step(1'b0, 1'b1, SRCB | IORD | MRD, "lw_mem_wait1");
    step(1'b1, 1'b0, SRCB | IORD | MRD, "lw_mem_ready");
    step(1'b1, 1'b0, RW | M2R, "lw_wb");
    exp_count = exp_count + 32'd1;
    chk("lw_wait_count", count, exp_count);

    // sw with reset asserted in the middle of a MEM wait
    opcode = 6'h2B; funct = 6'h00;
    step(1'b1, 1'b0, F_RDY, "sw_fetch");
    step(1'b1, 1'b0, '0, "sw_decode");
    step(1'b1, 1'b0, SRCB, "sw_exec");
    step(1'b0, 1'b0, SRCB | IORD | MWR, "sw_mem_wait0");
    mem_ready = 1'b0;
    #2;
    chk("sw_mem_wait1_write", 32'(mem_write), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_wait_outputs", 32'(pack_out()), 32'd0);
    chk("rst_mid_wait_count", count, 32'd0);
    chk("rst_mid_wait_state", 32'(state_dbg), 32'(ST_IDLE));
    exp_count = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b1, 1'b0, '0, "idle_after_mid_reset");
    run_instr(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
